// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes and system memory bus signals of mem_bus_arbiter.
// The tri-state data lines stay a plain inout port on the arbiter.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              r0_req, r1_req;
    logic              r0_we, r1_we;
    logic [ADDR_W-1:0] r0_addr, r1_addr;
    logic [DATA_W-1:0] r0_wdata, r1_wdata;
    logic              r0_ack, r1_ack;
    logic              r0_err, r1_err;
    logic [DATA_W-1:0] r0_rdata, r1_rdata;
    logic              rom_sel;
    logic [ADDR_W-1:0] addr_bus;
    logic              read_en, write_en;
    logic              owner, busy;

    modport slave (
        input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr,
               r0_wdata, r1_wdata, rom_sel,
        output r0_ack, r1_ack, r0_err, r1_err, r0_rdata, r1_rdata,
               addr_bus, read_en, write_en, owner, busy
    );

    modport master (
        output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr,
               r0_wdata, r1_wdata, rom_sel,
        input  r0_ack, r1_ack, r0_err, r1_err, r0_rdata, r1_rdata,
               addr_bus, read_en, write_en, owner, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter/sequencer for the shared ROM/RAM bus, with ROM write blocking.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed r0 priority.
module mem_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_bus_arbiter_if.slave        bus,
    inout  wire  [DATA_W-1:0]       ext_data_bus
);
    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;

    state_t            state_q, state_d;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack0_q, ack1_q, err0_q, err1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              elig0, elig1, grant, grant_sel;

`ifdef ARB_ROUND_ROBIN_EN
    // Last granted requester; starts at 1 so r0 takes the first tie.
    logic last_q;

    always_ff @(posedge clk) begin
        if (!reset)
            last_q <= 1'b1;
        else if (grant)
            last_q <= grant_sel;
    end
`endif

    always_comb begin
        // A requester still acked this cycle is holding req from the finished transfer.
        elig0     = bus.r0_req & ~ack0_q;
        elig1     = bus.r1_req & ~ack1_q;
        grant     = 1'b0;
        grant_sel = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                grant = elig0 | elig1;
`ifdef ARB_ROUND_ROBIN_EN
                grant_sel = (elig0 & elig1) ? ~last_q : elig1;
`else
                grant_sel = ~elig0 & elig1;
`endif
                if (grant)
                    state_d = (grant_sel ? bus.r1_we : bus.r0_we) ? WR : RD_ADDR;
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: state_d = IDLE;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            if (grant) begin
                owner_q <= grant_sel;
                addr_q  <= grant_sel ? bus.r1_addr  : bus.r0_addr;
                wdata_q <= grant_sel ? bus.r1_wdata : bus.r0_wdata;
            end
            case (state_q)
                RD_DATA: begin
                    if (owner_q) begin
                        ack1_q   <= 1'b1;
                        err1_q   <= 1'b0;
                        rdata1_q <= ext_data_bus;
                    end else begin
                        ack0_q   <= 1'b1;
                        err0_q   <= 1'b0;
                        rdata0_q <= ext_data_bus;
                    end
                end
                WR: begin
                    if (owner_q) begin
                        ack1_q <= 1'b1;
                        err1_q <= bus.rom_sel;
                    end else begin
                        ack0_q <= 1'b1;
                        err0_q <= bus.rom_sel;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.addr_bus = addr_q;
    assign bus.read_en  = (state_q == RD_ADDR) || (state_q == RD_DATA);
    assign bus.write_en = (state_q == WR) && !bus.rom_sel;
    assign bus.busy     = (state_q != IDLE);
    assign bus.owner    = owner_q;
    assign bus.r0_ack   = ack0_q;
    assign bus.r1_ack   = ack1_q;
    assign bus.r0_err   = err0_q;
    assign bus.r1_err   = err1_q;
    assign bus.r0_rdata = rdata0_q;
    assign bus.r1_rdata = rdata1_q;
    assign ext_data_bus = (state_q == WR) ? wdata_q : 'z;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: ROM/RAM model, random requesters, reference memory model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam logic [AW-1:0] ROM_TOP = 16'h4000;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    wire [DW-1:0] ext_data_bus;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .ext_data_bus (ext_data_bus)
    );

    always #5 clk = ~clk;

    // Synchronous memory: registers read data on the first read_en edge, drives it on the second cycle.
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] rd_q;
    logic          rd_phase;
    assign bus.rom_sel  = (bus.addr_bus < ROM_TOP);
    assign ext_data_bus = (bus.read_en && rd_phase) ? rd_q : 'z;
    always @(posedge clk) begin
        rd_phase <= bus.read_en;
        if (bus.read_en) rd_q <= mem[bus.addr_bus];
        if (bus.write_en) mem[bus.addr_bus] <= ext_data_bus;
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic [DW-1:0] ref_mem [0:65535];
    txn_t q0[$];
    txn_t q1[$];
    bit   grant_log[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0, re_cnt = 0, we_cnt = 0;
    bit   last_owner = 1'b0;
    bit   busy_d = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic score(input int r, input logic err, input logic [DW-1:0] rdata);
        txn_t t;
        bit   exp_err;
        if ((r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack_r%0d: got ack expected none", r);
            return;
        end
        if (r == 0) t = q0.pop_front();
        else        t = q1.pop_front();
        check($sformatf("owner_r%0d", r), last_owner, r[0]);
        if (t.we) begin
            exp_err = (t.addr < ROM_TOP);
            check($sformatf("wr_err_r%0d", r), err, exp_err);
            check("wr_busy_cycles", busy_run, 1);
            check("wr_strobe_cycles", we_cnt, exp_err ? 0 : 1);
            check("wr_read_en_cycles", re_cnt, 0);
            if (!exp_err) ref_mem[t.addr] = t.wdata;
        end else begin
            check($sformatf("rd_err_r%0d", r), err, 1'b0);
            check($sformatf("rd_data_r%0d_%0h", r, t.addr), rdata, ref_mem[t.addr]);
            check("rd_busy_cycles", busy_run, 2);
            check("rd_strobe_cycles", re_cnt, 2);
            check("rd_write_en_cycles", we_cnt, 0);
        end
    endtask

    // Monitor: samples on the falling edge, scores every ack against the owner's queue.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (bus.r0_ack || bus.r1_ack) check("dual_ack", bus.r0_ack & bus.r1_ack, 1'b0);
            if (bus.r0_ack) score(0, bus.r0_err, bus.r0_rdata);
            if (bus.r1_ack) score(1, bus.r1_err, bus.r1_rdata);
            if (bus.busy && !busy_d) grant_log.push_back(bus.owner);
            busy_d = bus.busy;
            if (!bus.busy) begin
                busy_run = 0;
                re_cnt   = 0;
                we_cnt   = 0;
            end else begin
                busy_run++;
                re_cnt += int'(bus.read_en);
                we_cnt += int'(bus.write_en);
                last_owner = bus.owner;
                if ((!bus.owner && q0.size() > 0) || (bus.owner && q1.size() > 0)) begin
                    t = bus.owner ? q1[0] : q0[0];
                    check("addr_bus", bus.addr_bus, t.addr);
                    if (bus.write_en) check("wr_data_bus", ext_data_bus, t.wdata);
                end
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_txn(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   n;
        bit   acked;
        txn_t t;
        t = txn_t'({we, a, d});
        if (r == 0) begin
            q0.push_back(t);
            bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d; bus.r0_req = 1'b1;
        end else begin
            q1.push_back(t);
            bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d; bus.r1_req = 1'b1;
        end
        n = 0;
        acked = 1'b0;
        while (!acked && n < 60) begin
            @(negedge clk);
            n++;
            acked = (r == 0) ? bus.r0_ack : bus.r1_ack;
        end
        if (!acked) begin
            checks++;
            errors++;
            $display("FAIL timeout_r%0d: no ack after %0d cycles, expected ack", r, n);
        end
        @(posedge clk);
        #1;
        if (r == 0) bus.r0_req = 1'b0;
        else        bus.r1_req = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000;
        return a | AW'($urandom_range(0, 15));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit prev_last;
        int n;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
        end
        mem[2]     = 8'h40;
        ref_mem[2] = 8'h40;
        bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr_bus", bus.addr_bus, 16'h0000);
        check("rst_read_en", bus.read_en, 1'b0);
        check("rst_write_en", bus.write_en, 1'b0);
        check("rst_acks", {bus.r0_ack, bus.r1_ack}, 2'b00);
        check("rst_errs", {bus.r0_err, bus.r1_err}, 2'b00);
        check("rst_rdata", {bus.r0_rdata, bus.r1_rdata}, 16'h0000);
        check("rst_owner", bus.owner, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);

        do_txn(0, 1'b0, 16'h0002, 8'h00);
        check("rom2_rdata", bus.r0_rdata, 8'h40);
        check("rom2_err", bus.r0_err, 1'b0);

        do_txn(1, 1'b1, 16'h8010, 8'h4A);
        check("ram_written", mem[16'h8010], 8'h4A);
        check("ram_wr_err", bus.r1_err, 1'b0);

        do_txn(0, 1'b1, 16'h0005, 8'hEE);
        check("rom_unchanged", mem[16'h0005], ref_mem[16'h0005]);
        check("rom_wr_err", bus.r0_err, 1'b1);

        // Simultaneous tie after an r0-only transfer.
        idle(3);
        grant_log.delete();
        fork
            do_txn(0, 1'b0, 16'h8010, 8'h00);
            do_txn(1, 1'b0, 16'h0002, 8'h00);
        join
        check("tie_grants", grant_log.size(), 2);
        if (grant_log.size() > 0) check("tie_winner", grant_log[0], RR ? 1'b1 : 1'b0);
        prev_last = (grant_log.size() > 1) ? grant_log[1] : 1'b0;

        // Continuous requests from both sides.
        idle(2);
        grant_log.delete();
        fork
            repeat (4) do_txn(0, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            repeat (4) do_txn(1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
        join
        check("cont_grants", grant_log.size(), 8);
        if (grant_log.size() > 0) check("cont_first", grant_log[0], RR ? ~prev_last : 1'b0);
        for (int i = 1; i < grant_log.size(); i++)
            check($sformatf("cont_alternate_%0d", i), grant_log[i] != grant_log[i-1], 1'b1);

        // Randomized traffic with gaps.
        idle(2);
        fork
            repeat (30) begin
                idle($urandom_range(0, 3));
                do_txn(0, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            end
            repeat (30) begin
                idle($urandom_range(0, 3));
                do_txn(1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            end
        join

        // Reset during RD_DATA aborts the read with no ack.
        idle(2);
        bus.r0_we = 1'b0; bus.r0_addr = 16'h8003; bus.r0_req = 1'b1;
        n = 0;
        while (re_cnt < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_rd_data", re_cnt, 2);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_read_en", bus.read_en, 1'b0);
        check("abort_write_en", bus.write_en, 1'b0);
        check("abort_ack", bus.r0_ack, 1'b0);
        @(posedge clk);
        #1;
        bus.r0_req = 1'b0;
        reset = 1'b1;
        idle(5);
        do_txn(0, 1'b0, 16'h8003, 8'h00);
        check("post_abort_rdata", bus.r0_rdata, ref_mem[16'h8003]);

        idle(3);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
